// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - pair state type, default pair table and pair-table decode for the collision matrix
package collision_pkg;

    typedef enum logic [1:0] {ARMED, IN_HIT, DONE} pair_state_t;

    typedef int unsigned obj_idx_t;

    localparam int TABLE_MAX_W = 128;

    // pair p = {objA, objB} at [p*2*IDX_W +: 2*IDX_W]; pairs (2,1), (3,0), (3,1)
    localparam logic [11:0] DEFAULT_PAIR_TABLE = {2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};

    function automatic obj_idx_t pair_obj(input logic [TABLE_MAX_W-1:0] table_bits,
                                          input int idx_w, input int p, input bit upper);
        obj_idx_t idx = 0;
        for (int b = 0; b < idx_w; b++)
            idx[b] = table_bits[p*2*idx_w + (upper ? idx_w : 0) + b];
        return idx;
    endfunction

endpackage

// File: rtl/collision_pair_fsm.sv
// rtl/collision_pair_fsm.sv - one pair: edge FSM with one-shot pulse, per-frame flag, saturating hit counter
module collision_pair_fsm
    import collision_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             hit,
    input  logic             enable,
    input  logic             cntClear,
    output logic             hitPulse,
    output logic             frameHit,
    output logic [CNT_W-1:0] hitCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pair_state_t state;
    logic        armed_now;
    logic        acc;

    // a new frame re-arms the pair before the current pixel is judged
    assign armed_now = (state == ARMED) || startOfFrame;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= ARMED;
            hitPulse <= 1'b0;
        end else begin
            hitPulse <= 1'b0;
            if (!enable) begin
                state <= ARMED;
            end else if (armed_now) begin
                if (hit) begin
                    state    <= IN_HIT;
                    // keeps the pulse one cycle wide if a frame starts right after a pulse
                    hitPulse <= !hitPulse;
                end else begin
                    state <= ARMED;
                end
            end else if (state == IN_HIT && !hit) begin
`ifdef FRAME_LOCK_EN
                state <= DONE;
`else
                state <= ARMED;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            acc      <= 1'b0;
            frameHit <= 1'b0;
        end else if (startOfFrame) begin
            frameHit <= acc | hit;
            acc      <= 1'b0;
        end else if (hit) begin
            acc <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || cntClear) begin
            hitCount <= '0;
        end else if (hitPulse && hitCount != CNT_MAX) begin
            hitCount <= hitCount + 1'b1;
        end
    end

endmodule

// File: rtl/collision_matrix_controller.sv
// rtl/collision_matrix_controller.sv - pairwise collision detector; define FRAME_LOCK_EN for one pulse per pair per frame
module collision_matrix_controller
    import collision_pkg::*;
#(
    parameter int                           NUM_OBJ    = 4,
    parameter int                           NUM_PAIRS  = 3,
    parameter int                           IDX_W      = 2,
    parameter logic [NUM_PAIRS*2*IDX_W-1:0] PAIR_TABLE = DEFAULT_PAIR_TABLE,
    parameter int                           CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_OBJ-1:0]         drawing_request,
    input  logic [NUM_PAIRS-1:0]       pairEnable,
    input  logic                       cntClear,
    output logic [NUM_PAIRS-1:0]       hitPulse,
    output logic [NUM_PAIRS-1:0]       frameHits,
    output logic [NUM_PAIRS*CNT_W-1:0] hitCount
);

    logic [NUM_PAIRS-1:0] hit;

    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        localparam int OBJ_A = int'(pair_obj(TABLE_MAX_W'(PAIR_TABLE), IDX_W, p, 1'b1));
        localparam int OBJ_B = int'(pair_obj(TABLE_MAX_W'(PAIR_TABLE), IDX_W, p, 1'b0));

        if (OBJ_A == OBJ_B) begin : g_bad_same
            $error("collision pair %0d compares object %0d with itself", p, OBJ_A);
        end
        if (OBJ_A >= NUM_OBJ || OBJ_B >= NUM_OBJ || IDX_W < $clog2(NUM_OBJ)) begin : g_bad_idx
            $error("collision pair %0d references an object outside 0..%0d", p, NUM_OBJ - 1);
        end

        assign hit[p] = drawing_request[OBJ_A] & drawing_request[OBJ_B] & pairEnable[p];

        collision_pair_fsm #(
            .CNT_W(CNT_W)
        ) u_pair (
            .clk         (clk),
            .resetN      (resetN),
            .startOfFrame(startOfFrame),
            .hit         (hit[p]),
            .enable      (pairEnable[p]),
            .cntClear    (cntClear),
            .hitPulse    (hitPulse[p]),
            .frameHit    (frameHits[p]),
            .hitCount    (hitCount[p*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_collision_matrix_controller.sv
// tb/tb_collision_matrix_controller.sv - scoreboard bench for collision_matrix_controller built with CNT_W=3
module tb_collision_matrix_controller;

    localparam int CW = 3;
`ifdef FRAME_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic [3:0]    drawing_request;
    logic [2:0]    pairEnable;
    logic          cntClear;
    logic [2:0]    hitPulse;
    logic [2:0]    frameHits;
    logic [3*CW-1:0] hitCount;

    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    collision_matrix_controller #(
        .CNT_W(CW)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .drawing_request(drawing_request),
        .pairEnable     (pairEnable),
        .cntClear       (cntClear),
        .hitPulse       (hitPulse),
        .frameHits      (frameHits),
        .hitCount       (hitCount)
    );

    task automatic drive(input logic [3:0] req, input logic sof, input logic [2:0] en, input logic clr);
        drawing_request = req;
        startOfFrame    = sof;
        pairEnable      = en;
        cntClear        = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        drive(4'b0000, 1'b1, 3'b111, 1'b1);
        drive(4'b0000, 1'b1, 3'b111, 1'b0);
    endtask

    task automatic test_reset();
        logic [2:0] got;
        resetN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b0, 3'b111, 1'b0);
            n_checks += 3;
            if (hitPulse !== 3'b000) begin n_fail++; $display("FAIL reset_pulse: got %b expected 000", hitPulse); end
            if (frameHits !== 3'b000) begin n_fail++; $display("FAIL reset_frame: got %b expected 000", frameHits); end
            if (hitCount !== '0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", hitCount); end
        end
        resetN = 1'b1;
        exp_q.push_back(3'b111);
        drive(4'b1111, 1'b0, 3'b111, 1'b0);
        got = exp_q.pop_front();
        n_checks++;
        if (hitPulse !== got) begin n_fail++; $display("FAIL reset_release_pulse: got %b expected %b", hitPulse, got); end
        exp_q.push_back(3'b000);
        drive(4'b0000, 1'b0, 3'b111, 1'b0);
        got = exp_q.pop_front();
        n_checks += 2;
        if (hitPulse !== got) begin n_fail++; $display("FAIL reset_release_after: got %b expected %b", hitPulse, got); end
        if (hitCount !== {3'd1, 3'd1, 3'd1}) begin n_fail++; $display("FAIL reset_release_count: got %b expected 001001001", hitCount); end
    endtask

    task automatic test_debounce();
        logic [2:0] got;
        logic prev_hit = 1'b0;
        logic seen = 1'b0;
        logic cur;
        int pulses = 0;
        quiesce();
        for (int i = 0; i < 14; i++) begin
            cur = (i < 5) || (i >= 8 && i < 12);
            got = {2'b00, cur & ~prev_hit & ~(LOCK & seen)};
            pulses += int'(got[0]);
            seen = seen | cur;
            prev_hit = cur;
            exp_q.push_back(got);
            drive(cur ? 4'b0110 : 4'b0000, 1'b0, 3'b111, 1'b0);
            got = exp_q.pop_front();
            n_checks++;
            if (hitPulse !== got) begin n_fail++; $display("FAIL debounce_pulse cycle %0d: got %b expected %b", i, hitPulse, got); end
        end
        n_checks++;
        if (hitCount[CW-1:0] !== CW'(pulses)) begin n_fail++; $display("FAIL debounce_count: got %0d expected %0d", hitCount[CW-1:0], pulses); end
        drive(4'b0000, 1'b1, 3'b111, 1'b0);
        n_checks++;
        if (frameHits !== 3'b001) begin n_fail++; $display("FAIL debounce_frame: got %b expected 001", frameHits); end
    endtask

    task automatic test_frame_boundary();
        logic [2:0] got;
        logic [9:0] req_on = 10'b00_0011_1111;
        logic [9:0] sof    = 10'b11_0000_1000;
        logic [9:0] pulse  = 10'b00_0000_1001;
        logic [9:0] fh     = 10'b01_1111_1000;
        quiesce();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({2'b00, pulse[i]});
            drive(req_on[i] ? 4'b0110 : 4'b0000, sof[i], 3'b111, 1'b0);
            got = exp_q.pop_front();
            n_checks += 2;
            if (hitPulse !== got) begin n_fail++; $display("FAIL frame_pulse cycle %0d: got %b expected %b", i, hitPulse, got); end
            if (frameHits !== {2'b00, fh[i]}) begin n_fail++; $display("FAIL frame_hits cycle %0d: got %b expected 00%b", i, frameHits, fh[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] got;
        int e;
        quiesce();
        for (int f = 0; f < 9; f++) begin
            drive(4'b0000, 1'b1, 3'b111, 1'b0);
            exp_q.push_back(3'b001);
            drive(4'b0110, 1'b0, 3'b111, 1'b0);
            got = exp_q.pop_front();
            n_checks++;
            if (hitPulse !== got) begin n_fail++; $display("FAIL sat_pulse frame %0d: got %b expected %b", f, hitPulse, got); end
            drive(4'b0000, 1'b0, 3'b111, 1'b0);
            e = (f + 1 > 7) ? 7 : f + 1;
            n_checks++;
            if (hitCount[CW-1:0] !== CW'(e)) begin n_fail++; $display("FAIL sat_count frame %0d: got %0d expected %0d", f, hitCount[CW-1:0], e); end
        end
        drive(4'b0000, 1'b1, 3'b111, 1'b0);
        exp_q.push_back(3'b001);
        drive(4'b0110, 1'b0, 3'b111, 1'b0);
        got = exp_q.pop_front();
        n_checks++;
        if (hitPulse !== got) begin n_fail++; $display("FAIL clear_pulse: got %b expected %b", hitPulse, got); end
        drive(4'b0000, 1'b0, 3'b111, 1'b1);
        n_checks++;
        if (hitCount !== '0) begin n_fail++; $display("FAIL clear_priority: got %b expected 0", hitCount); end
        drive(4'b0000, 1'b0, 3'b111, 1'b0);
        n_checks++;
        if (hitCount !== '0) begin n_fail++; $display("FAIL clear_hold: got %b expected 0", hitCount); end
    endtask

    task automatic test_enable();
        logic [2:0] got;
        logic [9:0] req_on = 10'b00_1111_1011;
        logic [9:0] sof    = 10'b10_0000_0100;
        logic [9:0] en1    = 10'b11_1011_0000;
        logic [9:0] pulse  = 10'b00_1001_0000;
        quiesce();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, pulse[i], 1'b0});
            drive(req_on[i] ? 4'b1001 : 4'b0000, sof[i], {1'b1, en1[i], 1'b1}, 1'b0);
            got = exp_q.pop_front();
            n_checks++;
            if (hitPulse !== got) begin n_fail++; $display("FAIL enable_pulse cycle %0d: got %b expected %b", i, hitPulse, got); end
            if (i == 2) begin
                n_checks++;
                if (frameHits !== 3'b000) begin n_fail++; $display("FAIL enable_frame_off: got %b expected 000", frameHits); end
            end
        end
        n_checks++;
        if (frameHits !== 3'b010) begin n_fail++; $display("FAIL enable_frame_on: got %b expected 010", frameHits); end
    endtask

    task automatic test_all_pairs();
        logic [2:0] got;
        quiesce();
        exp_q.push_back(3'b111);
        drive(4'b1111, 1'b0, 3'b111, 1'b0);
        got = exp_q.pop_front();
        n_checks++;
        if (hitPulse !== got) begin n_fail++; $display("FAIL all_pulse: got %b expected %b", hitPulse, got); end
        exp_q.push_back(3'b000);
        drive(4'b0000, 1'b0, 3'b111, 1'b0);
        got = exp_q.pop_front();
        n_checks += 2;
        if (hitPulse !== got) begin n_fail++; $display("FAIL all_pulse_width: got %b expected %b", hitPulse, got); end
        if (hitCount !== {3'd1, 3'd1, 3'd1}) begin n_fail++; $display("FAIL all_count: got %b expected 001001001", hitCount); end
    endtask

    initial begin
        resetN          = 1'b0;
        startOfFrame    = 1'b0;
        drawing_request = 4'b0000;
        pairEnable      = 3'b111;
        cntClear        = 1'b0;
        test_reset();
        test_debounce();
        test_frame_boundary();
        test_saturation();
        test_enable();
        test_all_pairs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
